barrier_ctrl: RTL

Multi-barrier controller that shares a pool of N_BARRIERS hardware barriers among N_PORTS requesters (cores or cluster sync units). Each port arrives on a barrier ID through a valid/ready handshake and blocks until every participant in that barrier's configured mask has arrived. The controller then pulses a wake to each participant and re-arms the barrier. It sits between the requesters and the per-barrier presence-tracking state, owning arrival bookkeeping, completion, clearing and configuration.

---
 rtl/barrier_ctrl_pkg.sv | 18 +
 rtl/barrier_slot.sv | 61 ++++++
 rtl/barrier_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/barrier_ctrl_pkg.sv
// barrier_ctrl_pkg: shared types and helpers for the barrier controller.
//   port_state_e : per-port arrival FSM state (StIdle, StWait)
//   calc_id_w()  : barrier ID width for a given barrier count, never below 1
package barrier_ctrl_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } port_state_e;

    function automatic int unsigned calc_id_w(input int unsigned n_barriers);
        if (n_barriers <= 1) begin
            return 1;
        end
        return $clog2(n_barriers);
    endfunction

endpackage

// File: rtl/barrier_slot.sv
// barrier_slot: state of one hardware barrier.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   cfg_we_i      : config write addressed to this barrier
//   cfg_mask_i    : participant mask to store
//   hs_i          : per-port accepted handshakes naming this barrier (members or not)
//   mask_o        : current participant mask (zero = disabled)
//   cfg_rej_o     : config write to this barrier is rejected this cycle
//   complete_o    : every participant has arrived (registered state only)
//   active_o      : at least one arrival recorded
module barrier_slot
    import barrier_ctrl_pkg::*;
#(
    parameter int unsigned N_PORTS = 4
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               cfg_we_i,
    input  logic [N_PORTS-1:0] cfg_mask_i,
    input  logic [N_PORTS-1:0] hs_i,
    output logic [N_PORTS-1:0] mask_o,
    output logic               cfg_rej_o,
    output logic               complete_o,
    output logic               active_o
);

    logic [N_PORTS-1:0] mask_q, mask_d;
    logic [N_PORTS-1:0] arrived_q, arrived_d;
    logic               cfg_ok;

    // Any handshake on this barrier blocks reconfiguration, even one that will error.
    assign cfg_ok     = cfg_we_i && (arrived_q == '0) && (hs_i == '0);
    assign cfg_rej_o  = cfg_we_i && !cfg_ok;
    assign complete_o = (mask_q != '0) && (arrived_q == mask_q);
    assign active_o   = |arrived_q;
    assign mask_o     = mask_q;

    always_comb begin
        mask_d    = mask_q;
        arrived_d = arrived_q;
        if (cfg_ok) begin
            mask_d = cfg_mask_i;
        end
        // Members of a complete barrier are all waiting, so no arrival can coincide.
        if (complete_o) begin
            arrived_d = '0;
        end else begin
            arrived_d = arrived_q | (hs_i & mask_q);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mask_q    <= '0;
            arrived_q <= '0;
        end else begin
            mask_q    <= mask_d;
            arrived_q <= arrived_d;
        end
    end

endmodule

// File: rtl/barrier_ctrl.sv
// barrier_ctrl: shares N_BARRIERS hardware barriers among N_PORTS requesters.
//   clk_i, rstn_i            : clock, asynchronous active-low reset
//   cfg_we_i/cfg_id_i/cfg_mask_i : barrier mask configuration write
//   cfg_err_o                : one-cycle pulse, config write rejected
//   req_valid_i/req_id_i     : per-port arrival request and packed barrier ID
//   req_ready_o              : port idle and able to arrive
//   wake_o                   : one-cycle pulse, barrier completed and port released
//   err_o                    : one-cycle pulse, arrival rejected
//   active_o                 : barrier holds at least one arrival
module barrier_ctrl
    import barrier_ctrl_pkg::*;
#(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned N_BARRIERS = 4,
    localparam int unsigned ID_W      = calc_id_w(N_BARRIERS)
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    cfg_we_i,
    input  logic [ID_W-1:0]         cfg_id_i,
    input  logic [N_PORTS-1:0]      cfg_mask_i,
    output logic                    cfg_err_o,
    input  logic [N_PORTS-1:0]      req_valid_i,
    input  logic [N_PORTS*ID_W-1:0] req_id_i,
    output logic [N_PORTS-1:0]      req_ready_o,
    output logic [N_PORTS-1:0]      wake_o,
    output logic [N_PORTS-1:0]      err_o,
    output logic [N_BARRIERS-1:0]   active_o
);

    port_state_e state_q [N_PORTS];
    port_state_e state_d [N_PORTS];

    logic [N_PORTS-1:0]    hs;
    logic [N_PORTS-1:0]    member;
    logic [N_PORTS-1:0]    hs_b   [N_BARRIERS];
    logic [N_PORTS-1:0]    mask_b [N_BARRIERS];
    logic [N_BARRIERS-1:0] cfg_sel;
    logic [N_BARRIERS-1:0] cfg_rej;
    logic [N_BARRIERS-1:0] complete;
    logic [N_PORTS-1:0]    wake_d, err_d;
    logic                  cfg_err_d;
    logic [N_PORTS-1:0]    wake_q, err_q;
    logic                  cfg_err_q;

    // ID decode. An out-of-range ID selects no slot, so it naturally falls into the
    // error path for arrivals and the reject path for config writes.
    always_comb begin
        hs      = '0;
        member  = '0;
        cfg_sel = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            hs[p] = req_valid_i[p] && (state_q[p] == StIdle);
        end
        for (int unsigned b = 0; b < N_BARRIERS; b++) begin
            hs_b[b]    = '0;
            cfg_sel[b] = cfg_we_i && (cfg_id_i == ID_W'(b));
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                hs_b[b][p] = hs[p] && (req_id_i[p*ID_W +: ID_W] == ID_W'(b));
            end
            member = member | (hs_b[b] & mask_b[b]);
        end
    end

    for (genvar b = 0; b < N_BARRIERS; b++) begin : g_slot
        barrier_slot #(
            .N_PORTS (N_PORTS)
        ) u_slot (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .cfg_we_i   (cfg_sel[b]),
            .cfg_mask_i (cfg_mask_i),
            .hs_i       (hs_b[b]),
            .mask_o     (mask_b[b]),
            .cfg_rej_o  (cfg_rej[b]),
            .complete_o (complete[b]),
            .active_o   (active_o[b])
        );
    end

    // Completing barriers have disjoint masks, so OR-ing them yields the wake set.
    always_comb begin
        wake_d = '0;
        for (int unsigned b = 0; b < N_BARRIERS; b++) begin
            if (complete[b]) begin
                wake_d = wake_d | mask_b[b];
            end
        end
        err_d     = hs & ~member;
        cfg_err_d = (cfg_we_i && (cfg_sel == '0)) || (cfg_rej != '0);
    end

    // Port FSM next state.
    always_comb begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            state_d[p] = state_q[p];
            unique case (state_q[p])
                StIdle: if (member[p]) state_d[p] = StWait;
                StWait: if (wake_d[p]) state_d[p] = StIdle;
                default: state_d[p] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                state_q[p] <= StIdle;
            end
        end else begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                state_q[p] <= state_d[p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wake_q    <= '0;
            err_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            wake_q    <= wake_d;
            err_q     <= err_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            req_ready_o[p] = (state_q[p] == StIdle);
        end
    end

    assign wake_o    = wake_q;
    assign err_o     = err_q;
    assign cfg_err_o = cfg_err_q;

endmodule
